// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle main controller for the MIPS datapath.
// Sequences IDLE/FETCH/DECODE/EXEC/MEM/WB and decodes op/funct into the datapath strobes.
// Latency: 2..5 cycles per instruction plus one cycle per dm_ready-low MEM cycle; stalls only in MEM.
// Ports:
//   clk, reset (async active-low)        - clock and reset
//   op, funct, zero, dm_ready            - IR fields, ALU zero flag, data memory handshake
//   ir_we, pc_we, pc_sel, ext_op         - IR/PC load, PC source, immediate extender mode
//   alu_op, alu_src_b                    - ALU operation and B-operand select
//   dm_req, dm_we                        - data memory request / store
//   rf_we, rf_wsel, rf_wdsel             - register file write, destination, data source
//   state, instr_cnt                     - debug state and retired-instruction count
module mc_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        dm_ready,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic [3:0]  ext_op,
  output logic [2:0]  alu_op,
  output logic        alu_src_b,
  output logic        dm_req,
  output logic        dm_we,
  output logic        rf_we,
  output logic [1:0]  rf_wsel,
  output logic [1:0]  rf_wdsel,
  output logic [2:0]  state,
  output logic [31:0] instr_cnt
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [31:0] instr_cnt_q, instr_cnt_d;

  // Instruction decode
  logic is_r, is_addu, is_subu, is_jr, is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal;
  logic is_jump;

  always_comb begin
    is_r    = (op == 6'b000000);
    is_addu = is_r && (funct == 6'b100001);
    is_subu = is_r && (funct == 6'b100011);
    is_jr   = is_r && (funct == 6'b001000);
    is_ori  = (op == 6'b001101);
    is_lui  = (op == 6'b001111);
    is_lw   = (op == 6'b100011);
    is_sw   = (op == 6'b101011);
    is_beq  = (op == 6'b000100);
    is_j    = (op == 6'b000010);
    is_jal  = (op == 6'b000011);
    // Jumps and unrecognised encodings both finish in DECODE.
    is_jump = is_j || is_jal || is_jr ||
              !(is_addu || is_subu || is_ori || is_lui || is_lw || is_sw || is_beq);
  end

  // State register and retired-instruction counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      instr_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  // Next state
  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = is_jump ? S_FETCH : S_EXEC;
      S_EXEC: begin
        if (is_lw || is_sw) state_d = S_MEM;
        else if (is_beq)    state_d = S_FETCH;
        else                state_d = S_WB;
      end
      S_MEM: begin
        if (!dm_ready)  state_d = S_MEM;
        else if (is_lw) state_d = S_WB;
        else            state_d = S_FETCH;
      end
      S_WB:     state_d = S_FETCH;
      default:  state_d = S_IDLE;
    endcase
  end

  // An instruction retires whenever we re-enter FETCH from anything but IDLE.
  always_comb begin
    instr_cnt_d = instr_cnt_q;
    if (state_d == S_FETCH && state_q != S_IDLE && state_q != S_FETCH)
      instr_cnt_d = instr_cnt_q + 32'd1;
  end

  // Outputs
  always_comb begin
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = 2'b00;
    ext_op    = 4'b0000;
    alu_op    = 3'b000;
    alu_src_b = 1'b0;
    dm_req    = 1'b0;
    dm_we     = 1'b0;
    rf_we     = 1'b0;
    rf_wsel   = 2'b00;
    rf_wdsel  = 2'b00;

    if (state_q == S_DECODE || state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
      if (is_ori)              ext_op = 4'b0001;
      else if (is_lw || is_sw) ext_op = 4'b0010;
      else if (is_lui)         ext_op = 4'b0011;
      else if (is_beq)         ext_op = 4'b0100;
    end

    case (state_q)
      S_FETCH: begin
        ir_we = 1'b1;
        pc_we = 1'b1;
      end
      S_DECODE: begin
        if (is_j || is_jal) begin
          pc_we  = 1'b1;
          pc_sel = 2'b10;
        end
        if (is_jal) begin
          // PC already holds PC+4, which is the return address.
          rf_we    = 1'b1;
          rf_wsel  = 2'b10;
          rf_wdsel = 2'b10;
        end
        if (is_jr) begin
          pc_we  = 1'b1;
          pc_sel = 2'b11;
        end
      end
      S_EXEC: begin
        if (is_subu) alu_op = 3'b001;
        if (is_ori) begin
          alu_op    = 3'b010;
          alu_src_b = 1'b1;
        end
        if (is_lui) begin
          alu_op    = 3'b011;
          alu_src_b = 1'b1;
        end
        if (is_lw || is_sw) alu_src_b = 1'b1;
        if (is_beq) begin
          alu_op = 3'b001;
          if (zero) begin
            pc_we  = 1'b1;
            pc_sel = 2'b01;
          end
        end
      end
      S_MEM: begin
        dm_req = 1'b1;
        dm_we  = is_sw;
      end
      S_WB: begin
        rf_we = 1'b1;
        if (is_ori || is_lui) rf_wsel = 2'b01;
        if (is_lw) begin
          rf_wsel  = 2'b01;
          rf_wdsel = 2'b01;
        end
      end
      default: ;
    endcase
  end

  assign state     = state_q;
  assign instr_cnt = instr_cnt_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed, table-driven check of mc_ctrl.
// One table record per clock cycle, applied back to back from reset release.
// A hand-written sequence covers asynchronous reset in the middle of a stalled store.
module tb_mc_ctrl;

  logic        clk;
  logic        reset;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic        zero;
  logic        dm_ready;
  logic        ir_we, pc_we, alu_src_b, dm_req, dm_we, rf_we;
  logic [1:0]  pc_sel, rf_wsel, rf_wdsel;
  logic [3:0]  ext_op;
  logic [2:0]  alu_op, state;
  logic [31:0] instr_cnt;

  mc_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .dm_ready(dm_ready),
    .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .ext_op(ext_op), .alu_op(alu_op),
    .alu_src_b(alu_src_b), .dm_req(dm_req), .dm_we(dm_we), .rf_we(rf_we),
    .rf_wsel(rf_wsel), .rf_wdsel(rf_wdsel), .state(state), .instr_cnt(instr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic        dm_ready;
    logic [2:0]  st;
    logic [18:0] ctrl;
    logic [31:0] cnt;
  } vec_t;

  vec_t vq[$];
  int   n_pass = 0;
  int   n_total = 0;

  // Control word: {ir_we,pc_we,pc_sel,ext_op,alu_op,alu_src_b,dm_req,dm_we,rf_we,rf_wsel,rf_wdsel}
  function automatic logic [18:0] cw(input logic ir, input logic pcw, input logic [1:0] pcs,
                                     input logic [3:0] ext, input logic [2:0] alu,
                                     input logic srcb, input logic req, input logic we,
                                     input logic rfwe, input logic [1:0] wsel,
                                     input logic [1:0] wdsel);
    return {ir, pcw, pcs, ext, alu, srcb, req, we, rfwe, wsel, wdsel};
  endfunction

  function automatic logic [18:0] dut_cw();
    return {ir_we, pc_we, pc_sel, ext_op, alu_op, alu_src_b, dm_req, dm_we, rf_we, rf_wsel, rf_wdsel};
  endfunction

  task automatic add(input logic [5:0] o, input logic [5:0] f, input logic z, input logic dr,
                     input logic [2:0] s, input logic [18:0] c, input logic [31:0] k);
    vec_t v;
    v.op = o; v.funct = f; v.zero = z; v.dm_ready = dr; v.st = s; v.ctrl = c; v.cnt = k;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
  endtask

  localparam logic [5:0] OP_R = 6'b000000, OP_ORI = 6'b001101, OP_LUI = 6'b001111,
                         OP_LW = 6'b100011, OP_SW = 6'b101011, OP_BEQ = 6'b000100,
                         OP_J = 6'b000010, OP_JAL = 6'b000011, OP_BAD = 6'b111111;
  localparam logic [5:0] F_ADDU = 6'b100001, F_SUBU = 6'b100011, F_JR = 6'b001000;

  localparam logic [18:0] C_FETCH = 19'b1_1_00_0000_000_0_0_0_0_00_00;

  initial begin
    logic [18:0] z0;
    z0 = 19'd0;
    //  op      funct   z  dr st ctrl                                              cnt
    // ori after reset release
    add(OP_ORI, 6'd0,   0, 0, 0, z0,                                                 0);
    add(OP_ORI, 6'd0,   0, 0, 1, C_FETCH,                                            0);
    add(OP_ORI, 6'd0,   0, 0, 2, cw(0,0,2'b00,4'd1,3'd0,0,0,0,0,2'b00,2'b00),        0);
    add(OP_ORI, 6'd0,   0, 0, 3, cw(0,0,2'b00,4'd1,3'd2,1,0,0,0,2'b00,2'b00),        0);
    add(OP_ORI, 6'd0,   0, 0, 5, cw(0,0,2'b00,4'd1,3'd0,0,0,0,1,2'b01,2'b00),        0);
    // lw with three wait cycles
    add(OP_LW,  6'd0,   0, 1, 1, C_FETCH,                                            1);
    add(OP_LW,  6'd0,   0, 1, 2, cw(0,0,2'b00,4'd2,3'd0,0,0,0,0,2'b00,2'b00),        1);
    add(OP_LW,  6'd0,   0, 1, 3, cw(0,0,2'b00,4'd2,3'd0,1,0,0,0,2'b00,2'b00),        1);
    add(OP_LW,  6'd0,   0, 0, 4, cw(0,0,2'b00,4'd2,3'd0,0,1,0,0,2'b00,2'b00),        1);
    add(OP_LW,  6'd0,   0, 0, 4, cw(0,0,2'b00,4'd2,3'd0,0,1,0,0,2'b00,2'b00),        1);
    add(OP_LW,  6'd0,   0, 0, 4, cw(0,0,2'b00,4'd2,3'd0,0,1,0,0,2'b00,2'b00),        1);
    add(OP_LW,  6'd0,   0, 1, 4, cw(0,0,2'b00,4'd2,3'd0,0,1,0,0,2'b00,2'b00),        1);
    add(OP_LW,  6'd0,   0, 0, 5, cw(0,0,2'b00,4'd2,3'd0,0,0,0,1,2'b01,2'b01),        1);
    // beq taken (zero also high in DECODE, where it must be ignored)
    add(OP_BEQ, 6'd0,   1, 0, 1, C_FETCH,                                            2);
    add(OP_BEQ, 6'd0,   1, 0, 2, cw(0,0,2'b00,4'd4,3'd0,0,0,0,0,2'b00,2'b00),        2);
    add(OP_BEQ, 6'd0,   1, 0, 3, cw(0,1,2'b01,4'd4,3'd1,0,0,0,0,2'b00,2'b00),        2);
    // beq not taken
    add(OP_BEQ, 6'd0,   0, 0, 1, C_FETCH,                                            3);
    add(OP_BEQ, 6'd0,   0, 0, 2, cw(0,0,2'b00,4'd4,3'd0,0,0,0,0,2'b00,2'b00),        3);
    add(OP_BEQ, 6'd0,   0, 1, 3, cw(0,0,2'b00,4'd4,3'd1,0,0,0,0,2'b00,2'b00),        3);
    // jal
    add(OP_JAL, 6'd0,   0, 0, 1, C_FETCH,                                            4);
    add(OP_JAL, 6'd0,   0, 0, 2, cw(0,1,2'b10,4'd0,3'd0,0,0,0,1,2'b10,2'b10),        4);
    // unknown opcode
    add(OP_BAD, 6'd0,   0, 0, 1, C_FETCH,                                            5);
    add(OP_BAD, 6'd0,   0, 0, 2, z0,                                                 5);
    // addu
    add(OP_R,   F_ADDU, 0, 0, 1, C_FETCH,                                            6);
    add(OP_R,   F_ADDU, 0, 0, 2, z0,                                                 6);
    add(OP_R,   F_ADDU, 0, 1, 3, z0,                                                 6);
    add(OP_R,   F_ADDU, 0, 0, 5, cw(0,0,2'b00,4'd0,3'd0,0,0,0,1,2'b00,2'b00),        6);
    // jr
    add(OP_R,   F_JR,   0, 0, 1, C_FETCH,                                            7);
    add(OP_R,   F_JR,   0, 0, 2, cw(0,1,2'b11,4'd0,3'd0,0,0,0,0,2'b00,2'b00),        7);
    // subu
    add(OP_R,   F_SUBU, 0, 0, 1, C_FETCH,                                            8);
    add(OP_R,   F_SUBU, 0, 0, 2, z0,                                                 8);
    add(OP_R,   F_SUBU, 1, 0, 3, cw(0,0,2'b00,4'd0,3'd1,0,0,0,0,2'b00,2'b00),        8);
    add(OP_R,   F_SUBU, 0, 0, 5, cw(0,0,2'b00,4'd0,3'd0,0,0,0,1,2'b00,2'b00),        8);
    // j
    add(OP_J,   6'd0,   0, 0, 1, C_FETCH,                                            9);
    add(OP_J,   6'd0,   0, 0, 2, cw(0,1,2'b10,4'd0,3'd0,0,0,0,0,2'b00,2'b00),        9);
    // lui
    add(OP_LUI, 6'd0,   0, 0, 1, C_FETCH,                                            10);
    add(OP_LUI, 6'd0,   0, 0, 2, cw(0,0,2'b00,4'd3,3'd0,0,0,0,0,2'b00,2'b00),        10);
    add(OP_LUI, 6'd0,   0, 0, 3, cw(0,0,2'b00,4'd3,3'd3,1,0,0,0,2'b00,2'b00),        10);
    add(OP_LUI, 6'd0,   0, 0, 5, cw(0,0,2'b00,4'd3,3'd0,0,0,0,1,2'b01,2'b00),        10);
    // sw, memory ready at once: exactly one MEM cycle
    add(OP_SW,  6'd0,   0, 0, 1, C_FETCH,                                            11);
    add(OP_SW,  6'd0,   0, 0, 2, cw(0,0,2'b00,4'd2,3'd0,0,0,0,0,2'b00,2'b00),        11);
    add(OP_SW,  6'd0,   0, 0, 3, cw(0,0,2'b00,4'd2,3'd0,1,0,0,0,2'b00,2'b00),        11);
    add(OP_SW,  6'd0,   0, 1, 4, cw(0,0,2'b00,4'd2,3'd0,0,1,1,0,2'b00,2'b00),        11);
    // R-type with unsupported funct behaves as a NOP
    add(OP_R,   6'd0,   0, 0, 1, C_FETCH,                                            12);
    add(OP_R,   6'd0,   0, 0, 2, z0,                                                 12);
    add(OP_SW,  6'd0,   0, 0, 1, C_FETCH,                                            13);

    reset = 1'b0; op = 6'd0; funct = 6'd0; zero = 1'b0; dm_ready = 1'b0;
    #1;
    chk("reset state", {29'd0, state}, 32'd0);
    chk("reset ctrl", {13'd0, dut_cw()}, 32'd0);
    chk("reset cnt", instr_cnt, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;

    foreach (vq[i]) begin
      op = vq[i].op; funct = vq[i].funct; zero = vq[i].zero; dm_ready = vq[i].dm_ready;
      #1;
      chk($sformatf("vec%0d state", i), {29'd0, state}, {29'd0, vq[i].st});
      chk($sformatf("vec%0d ctrl", i), {13'd0, dut_cw()}, {13'd0, vq[i].ctrl});
      chk($sformatf("vec%0d cnt", i), instr_cnt, vq[i].cnt);
      @(posedge clk); #1;
    end

    // sw stalled in MEM, then reset asserted between clock edges
    op = OP_SW; dm_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("sw stall state", {29'd0, state}, 32'd4);
    chk("sw stall req/we", {30'd0, dm_req, dm_we}, 32'd3);
    #2 reset = 1'b0;
    #1;
    chk("async rst state", {29'd0, state}, 32'd0);
    chk("async rst req/we", {30'd0, dm_req, dm_we}, 32'd0);
    chk("async rst ctrl", {13'd0, dut_cw()}, 32'd0);
    chk("async rst cnt", instr_cnt, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("post rst idle", {29'd0, state}, 32'd0);
    @(posedge clk); #1;
    chk("post rst fetch", {29'd0, state}, 32'd1);
    chk("post rst fetch ctrl", {13'd0, dut_cw()}, {13'd0, C_FETCH});
    chk("post rst cnt", instr_cnt, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle main controller for the MIPS datapath. It decodes the opcode/funct fields held in the instruction register and sequences fetch, decode, execute, memory and write-back over several clocks. In every cycle it drives the immediate-extender mode `ext_op`, the ALU, PC, register-file and data-memory controls. A retired-instruction counter is included for performance tests.

## Interface
Parameters:
- none; all encodings are fixed below.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `op`  in  6  IR[31:26].
- `funct`  in  6  IR[5:0].
- `zero`  in  1  ALU zero flag.
- `dm_ready`  in  1  data memory completes the current access.
- `ir_we`  out  1  load IR.
- `pc_we`  out  1  load PC.
- `pc_sel`  out  2  00 PC+4, 01 PC+(imm32), 10 {PC[31:28],IR[25:0],00}, 11 GPR[rs].
- `ext_op`  out  4  0000 zero, 0001 zero-ext, 0010 sign-ext, 0011 imm16<<16, 0100 sign-ext<<2.
- `alu_op`  out  3  000 add, 001 sub, 010 or, 011 pass B.
- `alu_src_b`  out  1  0 GPR[rt], 1 imm32.
- `dm_req`  out  1  data access request.
- `dm_we`  out  1  store when 1, load when 0.
- `rf_we`  out  1  register-file write.
- `rf_wsel`  out  2  00 rd, 01 rt, 10 $31.
- `rf_wdsel`  out  2  00 ALU result register, 01 memory data register, 10 current PC.
- `state`  out  3  current state, for debug.
- `instr_cnt`  out  32  retired instructions.

## Operation
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5.
- Supported instructions: addu (op 0, funct 100001), subu (0/100011), jr (0/001000), ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010, jal 000011. Any other op/funct is a NOP.
- Outputs are combinational from state, op, funct, zero and dm_ready. Every strobe not listed for a state is 0.
- IDLE: all outputs 0. The next state is FETCH.
- FETCH: `ir_we`=1, `pc_we`=1, `pc_sel`=00. The next state is DECODE.
- DECODE:
  - j: `pc_we`=1, `pc_sel`=10.
  - jal: same as j, plus `rf_we`=1, `rf_wsel`=10, `rf_wdsel`=10. PC is already PC+4, so $31 receives the return address.
  - jr: `pc_we`=1, `pc_sel`=11.
  - j, jal, jr and NOP go to FETCH. All others go to EXEC.
- EXEC, by instruction:
  - addu: `alu_op`=000.
  - subu: `alu_op`=001.
  - ori: `alu_op`=010, `alu_src_b`=1.
  - lui: `alu_op`=011, `alu_src_b`=1.
  - lw/sw: `alu_op`=000, `alu_src_b`=1.
  - beq: `alu_op`=001; if `zero`, `pc_we`=1 and `pc_sel`=01.
  - Next state: lw/sw go to MEM, beq goes to FETCH, the rest go to WB.
- MEM: `dm_req`=1, and `dm_we`=1 for sw. Stay in MEM while `dm_ready`=0. When `dm_ready`=1, lw goes to WB and sw goes to FETCH.
- WB: `rf_we`=1.
  - R-type: `rf_wsel`=00, `rf_wdsel`=00.
  - ori/lui: `rf_wsel`=01, `rf_wdsel`=00.
  - lw: `rf_wsel`=01, `rf_wdsel`=01.
  - The next state is FETCH.
- `ext_op` follows op in DECODE, EXEC, MEM and WB: ori 0001, lw/sw 0010, lui 0011, beq 0100, otherwise 0000. In IDLE and FETCH it is 0000.
- `instr_cnt` increments by 1, wrapping modulo 2^32, on every transition into FETCH from DECODE, EXEC, MEM or WB. IDLE→FETCH does not count.

## Timing
- Reset asserted: state becomes IDLE immediately without waiting for a clock. `instr_cnt` becomes 0, and every output is 0 in the same instant.
- Reset mid-instruction: the instruction is abandoned and `dm_req` drops asynchronously. The first FETCH comes 1 cycle after reset release.
- Cycle counts with zero memory wait:
  - j, jal, jr, NOP: 2.
  - beq: 3.
  - addu, subu, ori, lui, sw: 4.
  - lw: 5.
  - Each cycle in which `dm_ready` stays low adds 1 cycle.
- `dm_ready` is sampled only in MEM and ignored in every other state. A `dm_ready` high in the first MEM cycle gives exactly 1 MEM cycle.
- The beq decision uses `zero` in the single EXEC cycle only.

## Test plan
- Reset, release, op=001101 (ori) held → states 0,1,2,3,5,1. `ext_op`=0001 in cycles 2–4, `rf_we`=1 only in WB. `instr_cnt`=1 at the second FETCH.
- lw with `dm_ready` low for 3 MEM cycles → `dm_req`=1 and `dm_we`=0 for 4 cycles, then WB with `rf_wdsel`=01 and `rf_wsel`=01. 8 cycles total.
- beq with zero=1, then again with zero=0 → `pc_we`=1 and `pc_sel`=01 in EXEC only for the first; `ext_op`=0100 for both. 3 cycles each.
- jal → in DECODE: `pc_we`=1, `pc_sel`=10, `rf_we`=1, `rf_wsel`=10, `rf_wdsel`=10. Next state FETCH.
- op=111111 (NOP) → FETCH, DECODE, FETCH with no writes other than the FETCH strobes. `instr_cnt` increments by 1.
- Assert reset during MEM of sw with `dm_ready`=0 → `dm_req`, `dm_we`, `state` and `instr_cnt` become 0 immediately. After release the next cycle is FETCH.
